// File: rtl/vga_timing_gen.sv
// 640x480@60 Hz VGA raster timing generator: pixel-rate enable, raster counters,
// active-video qualifier, active-low syncs, line/frame strobes and a frame counter.
module vga_timing_gen #(
  parameter int CLK_DIV  = 4,
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33
) (
  input  logic       clk,
  input  logic       rst_n,
  output logic       pclk_en,
  output logic [9:0] h_cnt,
  output logic [9:0] v_cnt,
  output logic       valid,
  output logic       hsync,
  output logic       vsync,
  output logic       line_end,
  output logic       frame_start,
  output logic [7:0] frame_cnt
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int DW      = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;

  localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
  localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_VIS    = 10'(H_ACTIVE);
  localparam logic [9:0] V_VIS    = 10'(V_ACTIVE);
  localparam logic [9:0] HS_START = 10'(H_ACTIVE + H_FP);
  localparam logic [9:0] HS_END   = 10'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [9:0] VS_START = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0] VS_END   = 10'(V_ACTIVE + V_FP + V_SYNC);

  logic [DW-1:0] div_cnt;

  // Decodes are combinational from the registers so the pixel generator sees
  // counters and qualifiers coherently in the same cycle.
  assign pclk_en     = (div_cnt == DIV_LAST);
  assign line_end    = pclk_en && (h_cnt == H_LAST);
  assign frame_start = line_end && (v_cnt == V_LAST);
  assign valid       = (h_cnt < H_VIS) && (v_cnt < V_VIS);
  assign hsync       = !((h_cnt >= HS_START) && (h_cnt < HS_END));
  assign vsync       = !((v_cnt >= VS_START) && (v_cnt < VS_END));

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_cnt   <= '0;
      h_cnt     <= '0;
      v_cnt     <= '0;
      frame_cnt <= '0;
    end else begin
      div_cnt <= pclk_en ? '0 : div_cnt + 1'b1;
      if (pclk_en) begin
        if (h_cnt == H_LAST) begin
          h_cnt <= '0;
          v_cnt <= (v_cnt == V_LAST) ? '0 : v_cnt + 1'b1;
        end else begin
          h_cnt <= h_cnt + 1'b1;
        end
      end
      if (frame_start) frame_cnt <= frame_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_vga_timing_gen.sv
// Scoreboard bench: two instances (default VGA timing and a tiny raster) checked every
// cycle against an arithmetic model driven by the number of clock edges since reset.
module tb_vga_timing_gen;

  typedef struct packed {
    logic       pclk_en;
    logic [9:0] h;
    logic [9:0] v;
    logic       valid;
    logic       hsync;
    logic       vsync;
    logic       line_end;
    logic       frame_start;
    logic [7:0] fc;
  } obs_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic       pe_a, val_a, hs_a, vs_a, le_a, fs_a;
  logic [9:0] h_a, v_a;
  logic [7:0] fc_a;
  logic       pe_b, val_b, hs_b, vs_b, le_b, fs_b;
  logic [9:0] h_b, v_b;
  logic [7:0] fc_b;

  vga_timing_gen dut_a (
    .clk(clk), .rst_n(rst_n), .pclk_en(pe_a), .h_cnt(h_a), .v_cnt(v_a),
    .valid(val_a), .hsync(hs_a), .vsync(vs_a), .line_end(le_a),
    .frame_start(fs_a), .frame_cnt(fc_a)
  );

  vga_timing_gen #(
    .CLK_DIV(2), .H_ACTIVE(4), .H_FP(1), .H_SYNC(2), .H_BP(1),
    .V_ACTIVE(3), .V_FP(1), .V_SYNC(1), .V_BP(1)
  ) dut_b (
    .clk(clk), .rst_n(rst_n), .pclk_en(pe_b), .h_cnt(h_b), .v_cnt(v_b),
    .valid(val_b), .hsync(hs_b), .vsync(vs_b), .line_end(le_b),
    .frame_start(fs_b), .frame_cnt(fc_b)
  );

  // Expected outputs t clock edges after reset release, straight from the timing rules.
  function automatic obs_t model(int t, int cd, int ha, int hfp, int hs, int hbp,
                                 int va, int vfp, int vs, int vbp);
    obs_t o;
    int ht, vt, p, h, line, v;
    ht = ha + hfp + hs + hbp;
    vt = va + vfp + vs + vbp;
    p = t / cd;
    h = p % ht;
    line = p / ht;
    v = line % vt;
    o.pclk_en     = ((t % cd) == cd - 1);
    o.h           = 10'(h);
    o.v           = 10'(v);
    o.valid       = (h < ha) && (v < va);
    o.hsync       = !((h >= ha + hfp) && (h < ha + hfp + hs));
    o.vsync       = !((v >= va + vfp) && (v < va + vfp + vs));
    o.line_end    = o.pclk_en && (h == ht - 1);
    o.frame_start = o.line_end && (v == vt - 1);
    o.fc          = 8'((line / vt) % 256);
    return o;
  endfunction

  obs_t q_a[$];
  obs_t q_b[$];
  int   t = 0;
  int   cyc = 0;
  bit   done = 0;
  int   checks = 0;
  int   failures = 0;

  // One clock cycle of stimulus; optionally asserts or releases reset between edges.
  task automatic step(input bit do_assert, input bit do_release);
    @(posedge clk);
    if (rst_n) t++;
    #1;
    if (do_assert) begin
      rst_n = 1'b0;
      t = 0;
    end
    if (do_release) rst_n = 1'b1;
    cyc++;
    q_a.push_back(model(t, 4, 640, 16, 96, 48, 480, 10, 2, 33));
    q_b.push_back(model(t, 2, 4, 1, 2, 1, 3, 1, 1, 1));
  endtask

  task automatic compare(input string name, input obs_t act, input obs_t exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s cyc=%0d actual=%p required=%p", name, cyc, act, exp);
    end
  endtask

  initial begin
    fork
      begin : driver
        for (int i = 0; i < 10; i++) step(1'b0, 1'b0);
        step(1'b0, 1'b1);
        // 26000 clocks: ~8 default lines and ~270 tiny frames, crossing frame_cnt wrap.
        for (int i = 0; i < 26000; i++) step(1'b0, 1'b0);
        for (int r = 0; r < 6; r++) begin
          int run, hold;
          run  = $urandom_range(3000, 20);
          hold = $urandom_range(5, 1);
          step(1'b1, 1'b0);
          for (int i = 1; i < hold; i++) step(1'b0, 1'b0);
          step(1'b0, 1'b1);
          for (int i = 0; i < run; i++) step(1'b0, 1'b0);
        end
        done = 1;
      end
      begin : monitor
        while (!(done && q_a.size() == 0)) begin
          @(negedge clk);
          if (q_a.size() != 0) begin
            compare("dut_default", {pe_a, h_a, v_a, val_a, hs_a, vs_a, le_a, fs_a, fc_a},
                    q_a.pop_front());
            compare("dut_small", {pe_b, h_b, v_b, val_b, hs_b, vs_b, le_b, fs_b, fc_b},
                    q_b.pop_front());
          end
        end
      end
    join
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
